// File: rtl/coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// coin_input_conditioner
//   Front end for the vending-machine FSM. Takes the two raw, bouncy,
//   asynchronous coin-slot sensors and turns them into clean, single-cycle,
//   mutually exclusive credit pulses. Processing per channel:
//   synchronise -> debounce -> rising-edge detect -> pending credit.
//   A shared arbiter then issues at most one credit per cycle, coin1 first.
//   A slot whose debounced level stays high too long is flagged as jammed.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous, active-low reset
//   ena          in   enable; low freezes debounce/edge/credit/jam state and
//                     forces both pulses low (the synchroniser keeps running)
//   coin1_raw    in   raw 1-rupee sensor, active-high, may bounce
//   coin2_raw    in   raw 2-rupee sensor, active-high, may bounce
//   coin1_pulse  out  one-cycle pulse per accepted 1-rupee coin (FSM coinx)
//   coin2_pulse  out  one-cycle pulse per accepted 2-rupee coin (FSM coiny)
//   jam          out  either slot held high for JAM_CYCLES debounced cycles
//   db_level     out  debounced levels {coin2, coin1}
// ---------------------------------------------------------------------------
module coin_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int JAM_CYCLES      = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       coin1_raw,
   input  logic       coin2_raw,
   output logic       coin1_pulse,
   output logic       coin2_pulse,
   output logic       jam,
   output logic [1:0] db_level
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int JAM_W = $clog2(JAM_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [JAM_W-1:0] JAM_MAX = JAM_W'(JAM_CYCLES);

   // Saturating increment: the jam counter parks at JAM_MAX while the slot
   // stays high, so it can never wrap back and drop the jam flag.
   function automatic logic [JAM_W-1:0] jam_sat_inc(input logic [JAM_W-1:0] v);
      return (v == JAM_MAX) ? JAM_MAX : v + 1'b1;
   endfunction

   // Each entry carries both channels as {coin2, coin1}.
   logic [1:0]       sync_p0 [SYNC_STAGES];
   logic [1:0]       sync_val;

   logic [1:0]       db_p1, db_prev_p1, db_nxt, rise;
   logic [DB_W-1:0]  db_cnt     [2];
   logic [DB_W-1:0]  db_cnt_nxt [2];
   logic [JAM_W-1:0] jam_cnt     [2];
   logic [JAM_W-1:0] jam_cnt_nxt [2];
   logic [1:0]       jam_q, jam_nxt;

   logic [1:0]       pend_p2, pend_nxt;
   logic             pulse1_nxt, pulse2_nxt;

   assign sync_val = sync_p0[SYNC_STAGES-1];

   // ---- stage p0: synchroniser chain, free-running regardless of ena ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
      end else begin
         sync_p0[0] <= {coin2_raw, coin1_raw};
         for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      end
   end

   always_comb begin
      db_nxt     = db_p1;
      jam_nxt    = '0;
      rise       = db_p1 & ~db_prev_p1;
      pend_nxt   = pend_p2 | rise;
      pulse1_nxt = 1'b0;
      pulse2_nxt = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         db_cnt_nxt[ch]  = '0;
         jam_cnt_nxt[ch] = '0;
         // Any sample agreeing with the accepted level restarts the count.
         if (sync_val[ch] != db_p1[ch]) begin
            if (db_cnt[ch] == DB_LAST) db_nxt[ch] = sync_val[ch];
            else                       db_cnt_nxt[ch] = db_cnt[ch] + 1'b1;
         end
         if (db_p1[ch]) jam_cnt_nxt[ch] = jam_sat_inc(jam_cnt[ch]);
         // Looking at db_nxt drops the flag on the same edge the level falls.
         jam_nxt[ch] = db_nxt[ch] && (jam_cnt_nxt[ch] == JAM_MAX);
      end
      // A fresh rise on the granted channel keeps its credit pending.
      if (pend_p2[0]) begin
         pulse1_nxt  = 1'b1;
         pend_nxt[0] = rise[0];
      end else if (pend_p2[1]) begin
         pulse2_nxt  = 1'b1;
         pend_nxt[1] = rise[1];
      end
   end

   // ---- stage p1/p2: debounce, edge detect, credits, arbitration, jam ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_p1       <= '0;
         db_prev_p1  <= '0;
         pend_p2     <= '0;
         jam_q       <= '0;
         coin1_pulse <= 1'b0;
         coin2_pulse <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            db_cnt[ch]  <= '0;
            jam_cnt[ch] <= '0;
         end
      end else if (ena) begin
         db_p1       <= db_nxt;
         db_prev_p1  <= db_p1;
         pend_p2     <= pend_nxt;
         jam_q       <= jam_nxt;
         coin1_pulse <= pulse1_nxt;
         coin2_pulse <= pulse2_nxt;
         for (int ch = 0; ch < 2; ch++) begin
            db_cnt[ch]  <= db_cnt_nxt[ch];
            jam_cnt[ch] <= jam_cnt_nxt[ch];
         end
      end else begin
         coin1_pulse <= 1'b0;
         coin2_pulse <= 1'b0;
      end
   end

   assign jam      = |jam_q;
   assign db_level = db_p1;

endmodule
